// File: rtl/pent_ram_pkg.sv
// Shared types and constants for the Pentagon-style RAM arbiter: FSM state
// encoding, video slot indices, sub-phase markers and bus widths.
package pent_ram_pkg;

  localparam int unsigned RAM_AW = 19;
  localparam int unsigned RAM_DW = 8;

  localparam logic [1:0] SLOT_VPIX = 2'd0;
  localparam logic [1:0] SLOT_VATR = 2'd1;

  localparam logic [1:0] SUB_WE_START = 2'd1;
  localparam logic [1:0] SUB_WE_END   = 2'd2;
  localparam logic [1:0] SUB_CAPTURE  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VPIX   = 3'd1,
    ST_VATR   = 3'd2,
    ST_CPU_RD = 3'd3,
    ST_CPU_WR = 3'd4
  } arb_state_t;

  function automatic logic is_cpu_state(input arb_state_t s);
    return (s == ST_CPU_RD) || (s == ST_CPU_WR);
  endfunction

endpackage

// File: rtl/pent_slot_cnt.sv
// Free-running 16-clock phase counter split into four 4-clock slots; also
// flags the last clock of the period so the arbiter can sample vid_en there.
module pent_slot_cnt (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [1:0] o_slot,
  output logic [1:0] o_sub,
  output logic       o_period_last
);

  logic [3:0] r_ph;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ph <= 4'd0;
    end else begin
      r_ph <= r_ph + 4'd1;
    end
  end

  assign o_slot        = r_ph[3:2];
  assign o_sub         = r_ph[1:0];
  assign o_period_last = (r_ph == 4'hF);

endmodule

// File: rtl/pent_ram_arb.sv
// Time-sliced RAM arbiter: two video fetch slots and CPU slots per 16 clocks.
// Define PENT_RAM_ARB_WAIT_EN to drive cpu_wait_n low while a request queues.
module pent_ram_arb
  import pent_ram_pkg::*;
(
  input  logic              clk14m,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [RAM_AW-1:0] cpu_addr,
  input  logic [RAM_DW-1:0] cpu_wdata,
  output logic [RAM_DW-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_wait_n,
  input  logic              vid_en,
  input  logic [RAM_AW-1:0] vid_pix_addr,
  input  logic [RAM_AW-1:0] vid_atr_addr,
  output logic [RAM_DW-1:0] vid_pix,
  output logic [RAM_DW-1:0] vid_atr,
  output logic              vid_strobe,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [RAM_DW-1:0] ram_dout,
  input  logic [RAM_DW-1:0] ram_din,
  output logic              ram_oe,
  output logic              ram_cs_n,
  output logic              ram_we_n
);

  logic [1:0]        w_slot;
  logic [1:0]        w_sub;
  logic              w_period_last;
  logic [1:0]        w_slot_nxt;
  logic [1:0]        w_sub_nxt;
  logic              w_capture;
  logic              w_done;
  logic              w_vid_act_nxt;
  arb_state_t        w_state_nxt;
  logic [RAM_AW-1:0] w_addr_nxt;
  logic [RAM_DW-1:0] w_dout_nxt;

  arb_state_t        r_state;
  logic              r_vid_act;
  logic              r_armed;
  logic [RAM_AW-1:0] r_addr;
  logic [RAM_DW-1:0] r_dout;
  logic [RAM_DW-1:0] r_rdata;
  logic [RAM_DW-1:0] r_pix;
  logic [RAM_DW-1:0] r_atr;
  logic              r_ack;
  logic              r_strobe;
  logic              r_cs_n;
  logic              r_we_n;
  logic              r_oe;

  pent_slot_cnt u_slot_cnt (
    .i_clk         (clk14m),
    .i_rst         (rst),
    .o_slot        (w_slot),
    .o_sub         (w_sub),
    .o_period_last (w_period_last)
  );

  assign w_slot_nxt = w_slot + 2'd1;
  assign w_sub_nxt  = w_sub + 2'd1;
  assign w_capture  = (w_sub == SUB_CAPTURE);
  assign w_done     = is_cpu_state(r_state) && w_capture;

  // Next-slot decision is made on the last clock of the current slot so the
  // registered RAM strobes are already valid in the first clock of the slot.
  // A finishing CPU access blocks an immediate regrant on a still-held request.
  always_comb begin
    w_vid_act_nxt = w_period_last ? vid_en : r_vid_act;
    w_state_nxt   = r_state;
    w_addr_nxt    = r_addr;
    w_dout_nxt    = r_dout;
    if (w_capture) begin
      if (w_vid_act_nxt && (w_slot_nxt == SLOT_VPIX)) begin
        w_state_nxt = ST_VPIX;
        w_addr_nxt  = vid_pix_addr;
      end else if (w_vid_act_nxt && (w_slot_nxt == SLOT_VATR)) begin
        w_state_nxt = ST_VATR;
        w_addr_nxt  = vid_atr_addr;
      end else if (cpu_req && r_armed && !w_done) begin
        w_state_nxt = cpu_we ? ST_CPU_WR : ST_CPU_RD;
        w_addr_nxt  = cpu_addr;
        if (cpu_we) begin
          w_dout_nxt = cpu_wdata;
        end
      end else begin
        w_state_nxt = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk14m) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_vid_act <= 1'b0;
      r_armed   <= 1'b1;
      r_addr    <= '0;
      r_dout    <= '0;
      r_rdata   <= '0;
      r_pix     <= '0;
      r_atr     <= '0;
      r_ack     <= 1'b0;
      r_strobe  <= 1'b0;
      r_cs_n    <= 1'b1;
      r_we_n    <= 1'b1;
      r_oe      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_vid_act <= w_vid_act_nxt;
      r_addr    <= w_addr_nxt;
      r_dout    <= w_dout_nxt;
      r_cs_n    <= (w_state_nxt == ST_IDLE);
      r_oe      <= (w_state_nxt == ST_CPU_WR);
      r_we_n    <= !((w_state_nxt == ST_CPU_WR) &&
                     (w_sub_nxt >= SUB_WE_START) && (w_sub_nxt <= SUB_WE_END));
      r_ack     <= w_done;
      r_strobe  <= (r_state == ST_VATR) && w_capture;
      if (w_capture) begin
        case (r_state)
          ST_VPIX:   r_pix   <= ram_din;
          ST_VATR:   r_atr   <= ram_din;
          ST_CPU_RD: r_rdata <= ram_din;
          default:   ;
        endcase
      end
      // Re-arm only after the CPU has let go of its request.
      if (w_done) begin
        r_armed <= 1'b0;
      end else if (!cpu_req) begin
        r_armed <= 1'b1;
      end
    end
  end

`ifdef PENT_RAM_ARB_WAIT_EN
  assign cpu_wait_n = !(cpu_req && r_armed && !is_cpu_state(r_state) && !rst);
`else
  assign cpu_wait_n = 1'b1;
`endif

  assign cpu_rdata  = r_rdata;
  assign cpu_ack    = r_ack;
  assign vid_pix    = r_pix;
  assign vid_atr    = r_atr;
  assign vid_strobe = r_strobe;
  assign ram_addr   = r_addr;
  assign ram_dout   = r_dout;
  assign ram_oe     = r_oe;
  assign ram_cs_n   = r_cs_n;
  assign ram_we_n   = r_we_n;

endmodule

// File: tb/tb_pent_ram_arb.sv
// Directed self-checking bench for pent_ram_arb: video fetch, CPU read/write
// timing, held-request single access, dropped request and reset mid-write.
module tb_pent_ram_arb;

  logic        clk14m = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [18:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_wait_n;
  logic        vid_en = 1'b0;
  logic [18:0] vid_pix_addr = 19'h12345;
  logic [18:0] vid_atr_addr = 19'h06789;
  logic [7:0]  vid_pix;
  logic [7:0]  vid_atr;
  logic        vid_strobe;
  logic [18:0] ram_addr;
  logic [7:0]  ram_dout;
  logic [7:0]  ram_din = '0;
  logic        ram_oe;
  logic        ram_cs_n;
  logic        ram_we_n;

  int vectors = 0;
  int miscompares = 0;
  int tbPh = 0;
  int holdAccess = 0;
  int holdAck = 0;
  int dropHits = 0;
  int postAck = 0;

`ifdef PENT_RAM_ARB_WAIT_EN
  localparam logic EXP_WAIT = 1'b0;
`else
  localparam logic EXP_WAIT = 1'b1;
`endif

  pent_ram_arb dut (
    .clk14m       (clk14m),
    .rst          (rst),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_ack      (cpu_ack),
    .cpu_wait_n   (cpu_wait_n),
    .vid_en       (vid_en),
    .vid_pix_addr (vid_pix_addr),
    .vid_atr_addr (vid_atr_addr),
    .vid_pix      (vid_pix),
    .vid_atr      (vid_atr),
    .vid_strobe   (vid_strobe),
    .ram_addr     (ram_addr),
    .ram_dout     (ram_dout),
    .ram_din      (ram_din),
    .ram_oe       (ram_oe),
    .ram_cs_n     (ram_cs_n),
    .ram_we_n     (ram_we_n)
  );

  always #5 clk14m = ~clk14m;

  // tbPh tracks the phase the DUT is in during the cycle after each edge.
  task automatic tick();
    @(posedge clk14m);
    #1;
    tbPh = (tbPh + 1) % 16;
  endtask

  task automatic tickTo(input int target);
    for (int k = 0; k < 16 && tbPh != target; k++) tick();
  endtask

  task automatic applyStimulus(input logic req, input logic we,
                               input logic [18:0] addr, input logic [7:0] data);
    cpu_req   = req;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = data;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    $display("[TB] reset");
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tbPh = 0;
    checkOutput("rst_cs_n",   32'(ram_cs_n),   32'd1);
    checkOutput("rst_we_n",   32'(ram_we_n),   32'd1);
    checkOutput("rst_oe",     32'(ram_oe),     32'd0);
    checkOutput("rst_addr",   32'(ram_addr),   32'd0);
    checkOutput("rst_dout",   32'(ram_dout),   32'd0);
    checkOutput("rst_rdata",  32'(cpu_rdata),  32'd0);
    checkOutput("rst_ack",    32'(cpu_ack),    32'd0);
    checkOutput("rst_wait_n", 32'(cpu_wait_n), 32'd1);
    checkOutput("rst_pix",    32'(vid_pix),    32'd0);
    checkOutput("rst_atr",    32'(vid_atr),    32'd0);
    checkOutput("rst_strobe", 32'(vid_strobe), 32'd0);

    $display("[TB] video fetch");
    vid_en = 1'b1;
    tick();
    tickTo(0);
    for (int i = 0; i < 8; i++) begin
      ram_din = (tbPh < 4) ? 8'hA5 : 8'h3C;
      checkOutput("vid_cs_n", 32'(ram_cs_n), 32'd0);
      checkOutput("vid_we_n", 32'(ram_we_n), 32'd1);
      checkOutput("vid_addr", 32'(ram_addr), (tbPh < 4) ? 32'h12345 : 32'h06789);
      if (tbPh == 4) checkOutput("vid_pix_early", 32'(vid_pix), 32'hA5);
      tick();
    end
    checkOutput("vid_pix",       32'(vid_pix),    32'hA5);
    checkOutput("vid_atr",       32'(vid_atr),    32'h3C);
    checkOutput("vid_strobe_p8", 32'(vid_strobe), 32'd1);
    checkOutput("vid_idle_p8",   32'(ram_cs_n),   32'd1);
    tick();
    checkOutput("vid_strobe_p9", 32'(vid_strobe), 32'd0);

    $display("[TB] cpu read during display");
    tickTo(1);
    applyStimulus(1'b1, 1'b0, 19'h05ABC, 8'h00);
    checkOutput("rd_preempt_addr", 32'(ram_addr), 32'h12345);
    for (int i = 0; i < 7; i++) begin
      checkOutput("rd_wait_n", 32'(cpu_wait_n), 32'(EXP_WAIT));
      tick();
    end
    ram_din = 8'h5A;
    checkOutput("rd_grant_cs_n", 32'(ram_cs_n),   32'd0);
    checkOutput("rd_grant_addr", 32'(ram_addr),   32'h05ABC);
    checkOutput("rd_grant_oe",   32'(ram_oe),     32'd0);
    checkOutput("rd_grant_wait", 32'(cpu_wait_n), 32'd1);
    applyStimulus(1'b1, 1'b0, 19'h7FFFF, 8'h00);
    tickTo(11);
    checkOutput("rd_addr_latched", 32'(ram_addr), 32'h05ABC);
    checkOutput("rd_we_n",         32'(ram_we_n), 32'd1);
    tick();
    checkOutput("rd_rdata",   32'(cpu_rdata),  32'h5A);
    checkOutput("rd_ack_p12", 32'(cpu_ack),    32'd1);
    checkOutput("rd_no_regr", 32'(ram_cs_n),   32'd1);
    checkOutput("rd_wait_ak", 32'(cpu_wait_n), 32'd1);
    tick();
    checkOutput("rd_ack_p13", 32'(cpu_ack), 32'd0);
    applyStimulus(1'b0, 1'b0, 19'h00000, 8'h00);
    vid_en = 1'b0;

    $display("[TB] cpu write, display off");
    tick();
    applyStimulus(1'b1, 1'b1, 19'h1C000, 8'h77);
    tickTo(0);
    checkOutput("wr_p0_cs_n", 32'(ram_cs_n), 32'd0);
    checkOutput("wr_p0_oe",   32'(ram_oe),   32'd1);
    checkOutput("wr_p0_we_n", 32'(ram_we_n), 32'd1);
    checkOutput("wr_p0_addr", 32'(ram_addr), 32'h1C000);
    checkOutput("wr_p0_dout", 32'(ram_dout), 32'h77);
    applyStimulus(1'b1, 1'b1, 19'h1C000, 8'h11);
    tick();
    checkOutput("wr_p1_we_n", 32'(ram_we_n), 32'd0);
    checkOutput("wr_p1_dout", 32'(ram_dout), 32'h77);
    tick();
    checkOutput("wr_p2_we_n", 32'(ram_we_n), 32'd0);
    checkOutput("wr_p2_oe",   32'(ram_oe),   32'd1);
    tick();
    checkOutput("wr_p3_we_n", 32'(ram_we_n), 32'd1);
    checkOutput("wr_p3_oe",   32'(ram_oe),   32'd1);
    tick();
    checkOutput("wr_p4_ack",  32'(cpu_ack),  32'd1);
    checkOutput("wr_p4_oe",   32'(ram_oe),   32'd0);
    checkOutput("wr_p4_cs_n", 32'(ram_cs_n), 32'd1);

    $display("[TB] held request");
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ram_cs_n == 1'b0) holdAccess++;
      if (cpu_ack == 1'b1) holdAck++;
    end
    checkOutput("hold_accesses", 32'(holdAccess), 32'd0);
    checkOutput("hold_acks",     32'(holdAck),    32'd0);
    applyStimulus(1'b0, 1'b0, 19'h00000, 8'h00);
    tick();
    applyStimulus(1'b1, 1'b0, 19'h00001, 8'h00);
    tickTo(0);
    checkOutput("rearm_cs_n", 32'(ram_cs_n), 32'd0);
    checkOutput("rearm_addr", 32'(ram_addr), 32'h00001);
    ram_din = 8'hC3;
    tick();
    applyStimulus(1'b0, 1'b0, 19'h00000, 8'h00);
    tickTo(4);
    checkOutput("late_drop_ack",   32'(cpu_ack),   32'd1);
    checkOutput("late_drop_rdata", 32'(cpu_rdata), 32'hC3);

    $display("[TB] request dropped before grant");
    tick();
    applyStimulus(1'b1, 1'b0, 19'h02222, 8'h00);
    tick();
    applyStimulus(1'b0, 1'b0, 19'h00000, 8'h00);
    for (int i = 0; i < 8; i++) begin
      tick();
      if (ram_cs_n == 1'b0 || cpu_ack == 1'b1) dropHits++;
    end
    checkOutput("early_drop", 32'(dropHits), 32'd0);

    $display("[TB] reset during write");
    applyStimulus(1'b1, 1'b1, 19'h1ABCD, 8'hE1);
    tickTo(0);
    checkOutput("mid_p0_oe", 32'(ram_oe), 32'd1);
    tick();
    tick();
    checkOutput("mid_p2_we_n", 32'(ram_we_n), 32'd0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 19'h00000, 8'h00);
    tick();
    tbPh = 0;
    checkOutput("mid_rst_we_n",  32'(ram_we_n),   32'd1);
    checkOutput("mid_rst_oe",    32'(ram_oe),     32'd0);
    checkOutput("mid_rst_cs_n",  32'(ram_cs_n),   32'd1);
    checkOutput("mid_rst_addr",  32'(ram_addr),   32'd0);
    checkOutput("mid_rst_dout",  32'(ram_dout),   32'd0);
    checkOutput("mid_rst_rdata", 32'(cpu_rdata),  32'd0);
    checkOutput("mid_rst_ack",   32'(cpu_ack),    32'd0);
    checkOutput("mid_rst_pix",   32'(vid_pix),    32'd0);
    checkOutput("mid_rst_atr",   32'(vid_atr),    32'd0);
    checkOutput("mid_rst_wait",  32'(cpu_wait_n), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (cpu_ack == 1'b1) postAck++;
    end
    checkOutput("mid_rst_no_ack", 32'(postAck), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pent_ram_arb.md
PENT_RAM_ARB -- requirements
Module: pent_ram_arb

Interface
REQ-001 clk14m  in  1  master 14 MHz clock; all logic on rising edge.
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 cpu_req  in  1  CPU memory access request; level, held until cpu_ack.
REQ-004 cpu_we  in  1  1 = write, 0 = read; valid while cpu_req high.
REQ-005 cpu_addr  in  19  banked physical RAM address (page mapping done upstream).
REQ-006 cpu_wdata  in  8  write data.
REQ-007 cpu_rdata  out  8  registered read data.
REQ-008 cpu_ack  out  1  one-cycle pulse when the access completes.
REQ-009 cpu_wait_n  out  1  active-low CPU wait request.
REQ-010 vid_en  in  1  active display; video fetch slots enabled.
REQ-011 vid_pix_addr / vid_atr_addr  in  19 each  pixel / attribute byte addresses.
REQ-012 vid_pix, vid_atr  out  8 each  fetched pixel / attribute bytes.
REQ-013 vid_strobe  out  1  one-cycle pulse: both video bytes updated.
REQ-014 ram_addr  out  19;  ram_dout  out  8;  ram_din  in  8;  ram_oe  out  1 (drive MD with ram_dout);  ram_cs_n, ram_we_n  out  1 each.

Function
REQ-015 Free-running 4-bit phase counter ph wraps 15->0; slot = ph[3:2] (4 slots of 4 clocks); sub = ph[1:0].
REQ-016 vid_en sampled only at ph=0; sampled value governs slots 0-1 of that 16-clock period.
REQ-017 Slot 0 = VPIX, slot 1 = VATR when sampled vid_en=1; otherwise slots 0-1 are CPU slots. Slots 2-3 are always CPU slots.
REQ-018 FSM states: IDLE, VPIX, VATR, CPU_RD, CPU_WR; state chosen only at sub=0, held for 4 clocks.
REQ-019 VPIX/VATR: ram_addr = vid_pix_addr/vid_atr_addr, ram_cs_n=0, ram_we_n=1, ram_oe=0; ram_din captured at the sub=3 edge into vid_pix/vid_atr.
REQ-020 vid_strobe pulses in the cycle after the VATR capture (ph=8).
REQ-021 CPU slot grant at sub=0 only if cpu_req=1 and armed=1; otherwise IDLE (ram_cs_n=1).
REQ-022 CPU_RD: ram_addr = cpu_addr for all 4 clocks; ram_din captured into cpu_rdata at sub=3; cpu_ack pulses the following cycle.
REQ-023 CPU_WR: ram_addr and ram_dout = cpu_addr/cpu_wdata, ram_oe=1 for all 4 clocks; ram_we_n=0 at sub=1..2 only; cpu_ack pulses the cycle after sub=3.
REQ-024 armed clears on cpu_ack and sets when cpu_req is sampled low; prevents a second access on a held request.
REQ-025 cpu_req rising at sub!=0 waits for the next CPU-slot boundary; worst-case grant latency 11 clocks (during active display).
REQ-026 cpu_req dropped before grant: no RAM access, no ack. Dropped after grant: access completes, ack still pulses.
REQ-027 Address/data inputs latched at grant; later input changes do not affect the running access.
REQ-028 Video and CPU never drive the RAM in the same clock; video slots always preempt pending CPU requests.

Reset
REQ-029 On rst: ph=0, state IDLE, armed=1, ram_cs_n=1, ram_we_n=1, ram_oe=0, ram_addr=0, ram_dout=0, cpu_rdata=0, cpu_ack=0, cpu_wait_n=1, vid_pix=0, vid_atr=0, vid_strobe=0.
REQ-030 rst mid-access: ram_we_n=1 and ram_oe=0 at that same edge; transaction abandoned; no ack afterwards.

Configuration
REQ-031 Macro PENT_RAM_ARB_WAIT_EN. When defined: cpu_wait_n=0 in every cycle where cpu_req=1, armed=1, and no CPU access is granted or running; it returns to 1 in the grant cycle. When undefined: cpu_wait_n tied to 1 (Pentagon uncontended timing); queueing per REQ-021..025 is unchanged.

Structure
REQ-032 Package pent_ram_pkg holds the FSM state enum, slot indices (SLOT_VPIX=0, SLOT_VATR=1), sub-phase constants (SUB_WE_START=1, SUB_WE_END=2, SUB_CAPTURE=3), and widths (RAM_AW=19, RAM_DW=8).
REQ-033 One sub-module, pent_slot_cnt: phase counter plus decoded slot/sub outputs; the arbiter FSM stays in pent_ram_arb.

Verification
REQ-034 vid_en=1, no cpu_req, ram_din=8'hA5 during slot 0 and 8'h3C during slot 1 -> vid_pix=A5, vid_atr=3C, vid_strobe high at ph=8.
REQ-035 cpu_req read at ph=1, addr=19'h05ABC, vid_en=1, ram_din=8'h5A -> grant at ph=8, cpu_rdata=5A, cpu_ack at ph=12; with WAIT_EN, cpu_wait_n low ph=1..7.
REQ-036 Write addr=19'h1C000, data=8'h77 with vid_en=0 granted at ph=0 -> ram_we_n low only at ph=1..2, ram_oe high ph=0..3, ack at ph=4.
REQ-037 cpu_req held high for 40 clocks after ack -> exactly one RAM access; the next access occurs only after a 1-cycle req low.
REQ-038 rst asserted at ph=2 of a CPU_WR -> ram_we_n=1 next edge, all outputs at reset values, no cpu_ack.
